lvda_phase_timing: RTL and testbench

- Upstream timing stage for the LVDA processor-store and delay-line logic.
- Divides the simulation clock into bit times. Each bit time has four phases, W, X, Y and Z, and each phase has numbered steps 1..6.
- Drives the step strobes (V1, V5) and phase-step decodes (W4, X4, Y5, Y6, Z4) consumed by the store's latch and delay-line driver logic.
- Counts bit times within a word and provides run/halt/single-step control.

---
 rtl/lvda_phase_timing.sv | 152 +++++++++++++++
 tb/tb_lvda_phase_timing.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvda_phase_timing.sv
// LVDA phase timing: divides SIM_CLK into bit times of four phases (W,X,Y,Z)
// of STEPS_PER_PHASE steps, decodes strobes, and controls run/halt/step.
module lvda_phase_timing #(
   parameter int STEPS_PER_PHASE = 6,
   parameter int BITS_PER_WORD   = 28,
   parameter int BIT_W           = 6
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic             RUN,
   input  logic             STEP,
   output logic             V1,
   output logic             V5,
   output logic             W4,
   output logic             X4,
   output logic             Y5,
   output logic             Y6,
   output logic             Z4,
   output logic [BIT_W-1:0] BIT,
   output logic             WORD_END,
   output logic             BUSY
);

   typedef enum logic [2:0] {
      S_HALT, S_SYNC, S_RUN, S_DRAIN, S_SSTEP
   } state_t;

   localparam logic [3:0]       LAST_STEP = 4'(STEPS_PER_PHASE);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BITS_PER_WORD - 1);
   localparam logic [1:0]       PH_W = 2'd0;
   localparam logic [1:0]       PH_X = 2'd1;
   localparam logic [1:0]       PH_Y = 2'd2;
   localparam logic [1:0]       PH_Z = 2'd3;

   state_t           state_q, state_d;
   logic [3:0]       step_q, step_d;
   logic [1:0]       phase_q, phase_d;
   logic [BIT_W-1:0] bit_q, bit_d;

   logic             last_step, bit_end, word_end;
   logic [BIT_W-1:0] bit_inc;
   logic [3:0]       step_a;
   logic [1:0]       phase_a;
   logic [BIT_W-1:0] bit_a;
   logic             op_d;

   // Free-running advance of step/phase/bit used by all operating states
   always_comb begin
      last_step = (step_q == LAST_STEP);
      bit_end   = last_step && (phase_q == PH_Z);
      word_end  = bit_end && (bit_q == LAST_BIT);
      bit_inc   = (bit_q == LAST_BIT) ? '0 : bit_q + BIT_W'(1);
      step_a    = last_step ? 4'd1 : step_q + 4'd1;
      phase_a   = last_step ? phase_q + 2'd1 : phase_q;
      bit_a     = bit_end ? bit_inc : bit_q;
   end

   // Next-state: run/halt/single-step sequencing of the counters
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      unique case (state_q)
         S_HALT: begin
            if (RUN) begin
               state_d = S_SYNC;
            end else if (STEP) begin
               state_d = S_SSTEP;
               step_d  = 4'd1;
               phase_d = PH_W;
            end
         end
         S_SYNC: begin
            state_d = S_RUN;
            step_d  = 4'd1;
            phase_d = PH_W;
            bit_d   = '0;
         end
         S_RUN, S_DRAIN: begin
            if (!RUN && word_end) begin
               state_d = S_HALT;
               step_d  = 4'd0;
               phase_d = PH_W;
               bit_d   = '0;
            end else begin
               state_d = RUN ? S_RUN : S_DRAIN;
               step_d  = step_a;
               phase_d = phase_a;
               bit_d   = bit_a;
            end
         end
         S_SSTEP: begin
            if (bit_end) begin
               state_d = S_HALT;
               step_d  = 4'd0;
               phase_d = PH_W;
               bit_d   = bit_inc;
            end else begin
               step_d  = step_a;
               phase_d = phase_a;
               bit_d   = bit_a;
            end
         end
         default: begin
            state_d = S_HALT;
            step_d  = 4'd0;
            phase_d = PH_W;
            bit_d   = '0;
         end
      endcase
      op_d = (state_d == S_RUN) || (state_d == S_DRAIN) ||
             (state_d == S_SSTEP);
   end

   // State registers and outputs decoded from next state, so they stay aligned
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state_q  <= S_HALT;
         step_q   <= 4'd0;
         phase_q  <= PH_W;
         bit_q    <= '0;
         V1       <= 1'b0;
         V5       <= 1'b0;
         W4       <= 1'b0;
         X4       <= 1'b0;
         Y5       <= 1'b0;
         Y6       <= 1'b0;
         Z4       <= 1'b0;
         WORD_END <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         phase_q  <= phase_d;
         bit_q    <= bit_d;
         V1       <= op_d && !(phase_d == PH_W && step_d == 4'd1);
         V5       <= op_d && (step_d == 4'd5);
         W4       <= op_d && (phase_d == PH_W) && (step_d == 4'd4);
         X4       <= op_d && (phase_d == PH_X) && (step_d == 4'd4);
         Y5       <= op_d && (phase_d == PH_Y) && (step_d == 4'd5);
         Y6       <= op_d && (phase_d == PH_Y) && (step_d == 4'd6);
         Z4       <= op_d && (phase_d == PH_Z) && (step_d == 4'd4);
         WORD_END <= op_d && (phase_d == PH_Z) && (step_d == LAST_STEP) &&
                     (bit_d == LAST_BIT);
         BUSY     <= (state_d != S_HALT);
      end
   end

   assign BIT = bit_q;

endmodule

// File: tb/tb_lvda_phase_timing.sv
// Bench for lvda_phase_timing: per-cycle scoreboard against a tick-count
// model, plus a fixed table of first-bit timing points and corner sequences.
module tb_lvda_phase_timing;

   localparam int S   = 6;
   localparam int BPW = 28;
   localparam int BT  = 4 * S;

   logic       clk = 1'b0;
   logic       rst, run, stp;
   logic       v1, v5, w4, x4, y5, y6, z4, we, busy;
   logic [5:0] bitv;

   typedef struct packed {
      logic       busy, v1, v5, w4, x4, y5, y6, z4, we;
      logic [5:0] bitv;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t exp;
   } vec_t;

   lvda_phase_timing #(.STEPS_PER_PHASE(S), .BITS_PER_WORD(BPW), .BIT_W(6)) dut (
      .SIM_CLK(clk), .SIM_RST(rst), .RUN(run), .STEP(stp),
      .V1(v1), .V5(v5), .W4(w4), .X4(x4), .Y5(y5), .Y6(y6), .Z4(z4),
      .BIT(bitv), .WORD_END(we), .BUSY(busy)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   obs_t sbq[$];
   obs_t last;

   // model: 0 halt, 1 sync, 2 run, 3 drain, 4 sstep; t = clock within bit
   int md = 0;
   int t  = 0;
   int b  = 0;

   function automatic obs_t mk(input logic bu, v1e, v5e, w4e, x4e, y5e,
                               y6e, z4e, wee, input int bv);
      obs_t o;
      o = {bu, v1e, v5e, w4e, x4e, y5e, y6e, z4e, wee, 6'(bv)};
      return o;
   endfunction

   task automatic adv();
      if (t == BT - 1) begin
         t = 0;
         b = (b + 1) % BPW;
      end else begin
         t = t + 1;
      end
   endtask

   task automatic mstep(input logic r, input logic s, input logic x);
      bit eow;
      eow = (t == BT - 1) && (b == BPW - 1);
      if (x) begin
         md = 0; t = 0; b = 0;
      end else begin
         case (md)
            0: if (r) md = 1;
               else if (s) begin md = 4; t = 0; end
            1: begin md = 2; t = 0; b = 0; end
            2, 3: if (!r && eow) begin md = 0; t = 0; b = 0; end
                  else begin md = r ? 2 : 3; adv(); end
            4: if (t == BT - 1) begin md = 0; t = 0; b = (b + 1) % BPW; end
               else adv();
            default: md = 0;
         endcase
      end
   endtask

   function automatic obs_t mexp();
      bit op;
      op = (md >= 2);
      return mk(md != 0, op && t != 0, op && (t % S) == 4, op && t == 3,
                op && t == S + 3, op && t == 2 * S + 4, op && t == 2 * S + 5,
                op && t == 3 * S + 3, op && t == BT - 1 && b == BPW - 1, b);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input logic r, input logic s, input logic x);
      obs_t e;
      run = r; stp = s; rst = x;
      mstep(r, s, x);
      sbq.push_back(mexp());
      @(posedge clk);
      #1;
      cyc++;
      last = {busy, v1, v5, w4, x4, y5, y6, z4, we, bitv};
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL sb_empty cyc=%0d", cyc);
      end else begin
         e = sbq.pop_front();
         if (last !== e) begin
            errors++;
            $display("FAIL sb cyc=%0d got %h expected %h", cyc, last, e);
         end
      end
   endtask

   vec_t tab[12];

   initial begin
      int k, g, wn, w1, w2, low, cnt;
      bit seen;
      tab[0]  = '{10, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tab[1]  = '{11, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tab[2]  = '{12, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tab[3]  = '{13, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tab[4]  = '{15, mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0)};
      tab[5]  = '{16, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
      tab[6]  = '{21, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0)};
      tab[7]  = '{28, mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0)};
      tab[8]  = '{29, mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
      tab[9]  = '{33, mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
      tab[10] = '{35, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tab[11] = '{36, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)};

      // reset and 50 idle clocks
      tick(0, 0, 1);
      tick(0, 0, 1);
      chk("reset_outs", int'(last), 0);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick(0, 0, 0);
         if (last != '0) cnt++;
      end
      chk("idle_nonzero_cycles", cnt, 0);

      // first-bit timing table, RUN seen at edge 11
      k = 0;
      for (int c = 1; c <= 40; c++) begin
         tick(c >= 11, 0, 0);
         if (k < 12 && tab[k].cyc == c) begin
            chk($sformatf("tab_cyc%0d", c), int'(last), int'(tab[k].exp));
            k++;
         end
      end

      // two words of continuous run
      wn = 0; w1 = 0; w2 = 0;
      for (int i = 0; i < 2 * BT * BPW; i++) begin
         tick(1, 0, 0);
         if (last.we) begin
            chk("we_bit", int'(last.bitv), BPW - 1);
            wn++;
            if (wn == 1) w1 = cyc;
            if (wn == 2) w2 = cyc;
         end
      end
      chk("we_count", wn, 2);
      chk("we_spacing", w2 - w1, BT * BPW);

      // drop RUN at BIT=5, drain to end of word
      g = 0;
      while (last.bitv != 6'd5 && g < 800) begin tick(1, 0, 0); g++; end
      chk("reach_bit5", int'(last.bitv), 5);
      seen = 0; g = 0;
      while (last.busy && g < 800) begin
         tick(0, 0, 0);
         if (last.we) seen = 1;
         g++;
      end
      chk("drain_halt_busy", int'(last.busy), 0);
      chk("drain_we_seen", int'(seen), 1);
      chk("drain_bit0", int'(last.bitv), 0);

      // RUN re-raised mid-drain: no gap, no SYNC
      low = 0;
      for (int i = 0; i < 100; i++) tick(1, 0, 0);
      for (int i = 0; i < 30; i++) begin
         tick(0, 0, 0); if (!last.busy) low++;
      end
      for (int i = 0; i < 30; i++) begin
         tick(1, 0, 0); if (!last.busy) low++;
      end
      chk("redrain_busy_gap", low, 0);
      g = 0;
      while (last.busy && g < 800) begin tick(0, 0, 0); g++; end
      chk("redrain_halt", int'(last.busy), 0);
      chk("redrain_bit0", int'(last.bitv), 0);

      // three single steps, with a stray STEP inside each
      seen = 0;
      for (int n = 0; n < 3; n++) begin
         cnt = 0; g = 0;
         tick(0, 1, 0);
         while (last.busy && g < 40) begin
            cnt++;
            if (last.we) seen = 1;
            tick(0, cnt == 5, 0);
            g++;
         end
         chk($sformatf("sstep%0d_len", n), cnt, BT);
      end
      chk("sstep_bit3", int'(last.bitv), 3);
      chk("sstep_no_we", int'(seen), 0);

      // reset during Y step 3, restart with RUN held
      g = 0;
      tick(1, 0, 0);
      while (!(md == 2 && t == 2 * S + 2) && g < 100) begin
         tick(1, 0, 0); g++;
      end
      chk("reach_y3", t, 2 * S + 2);
      tick(1, 0, 1);
      chk("rst_mid_outs", int'(last), 0);
      tick(1, 0, 0);
      chk("rst_sync", int'(last), int'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tick(1, 0, 0);
      chk("rst_w1", int'(last), int'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tick(1, 0, 0);
      chk("rst_w2", int'(last), int'(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
